// File: rtl/piso_serializer_param_if.sv
// Load handshake, control and serial-status bundle of the parametrised PISO serializer.
interface piso_serializer_param_if #(parameter int WIDTH = 16);
  logic             Enable_In;
  logic             Data_Valid_In;
  logic             Data_Ready_Out;
  logic [WIDTH-1:0] Parallel_Data_In;
  logic             Lsb_First_In;
  logic             Bit_Tick_In;
  logic             Serial_Data_Out;
  logic             Serial_Valid_Out;
  logic             Busy_Out;
  logic             Frame_Done_Out;

  modport master (
    output Enable_In, Data_Valid_In, Parallel_Data_In, Lsb_First_In, Bit_Tick_In,
    input  Data_Ready_Out, Serial_Data_Out, Serial_Valid_Out, Busy_Out, Frame_Done_Out
  );

  modport slave (
    input  Enable_In, Data_Valid_In, Parallel_Data_In, Lsb_First_In, Bit_Tick_In,
    output Data_Ready_Out, Serial_Data_Out, Serial_Valid_Out, Busy_Out, Frame_Done_Out
  );
endinterface

// File: rtl/piso_serializer_param.sv
// Parametrised parallel-in/serial-out serializer with valid/ready load, bit-rate strobe,
// per-frame bit order and zero-gap back-to-back streaming.
//
//   state | meaning
//   IDLE  | no frame; output at IDLE_LEVEL, ready for a load
//   SHIFT | frame in progress; one bit consumed per Bit_Tick_In
module piso_serializer_param #(
  parameter int   WIDTH      = 16,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input logic                    Clk_In,
  input logic                    Reset_In,
  piso_serializer_param_if.slave bus
);
  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             lsb_q, lsb_nxt;
  logic             done_q, done_nxt;
  logic             last_tick, ready, load;

  assign last_tick = (state == SHIFT) && (cnt == LAST) && bus.Bit_Tick_In;
  assign ready     = bus.Enable_In && !Reset_In && ((state == IDLE) || last_tick);
  assign load      = ready && bus.Data_Valid_In;

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state  <= IDLE;
      shreg  <= {WIDTH{IDLE_LEVEL}};
      cnt    <= '0;
      lsb_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      shreg  <= shreg_nxt;
      cnt    <= cnt_nxt;
      lsb_q  <= lsb_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    lsb_nxt   = lsb_q;
    done_nxt  = 1'b0;
    if (bus.Enable_In) begin
      if ((state == SHIFT) && bus.Bit_Tick_In) begin
        if (cnt != LAST) begin
          shreg_nxt = lsb_q ? {IDLE_LEVEL, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], IDLE_LEVEL};
          cnt_nxt   = cnt + 1'b1;
        end else begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
          shreg_nxt = {WIDTH{IDLE_LEVEL}};
          cnt_nxt   = '0;
        end
      end
      // A load on the last tick overrides the return to IDLE, giving zero-gap streaming.
      if (load) begin
        state_nxt = SHIFT;
        shreg_nxt = bus.Parallel_Data_In;
        cnt_nxt   = '0;
        lsb_nxt   = bus.Lsb_First_In;
      end
    end
  end

  assign bus.Data_Ready_Out   = ready;
  assign bus.Serial_Data_Out  = (state == SHIFT) ? (lsb_q ? shreg[0] : shreg[WIDTH-1]) : IDLE_LEVEL;
  assign bus.Serial_Valid_Out = (state == SHIFT);
  assign bus.Busy_Out         = (state == SHIFT);
  assign bus.Frame_Done_Out   = done_q && bus.Enable_In;
endmodule
